// File: rtl/sym_pkg.sv
// Shared types and constants for the symbol score tracker.
package sym_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    WINDOW = 2'd2
  } state_t;

  localparam logic [7:0]  SYM_RESET       = 8'hFF;
  localparam int unsigned DEF_CNT_W       = 16;
  localparam int unsigned DEF_RESP_WINDOW = 50000000;
  localparam int unsigned WIN_W           = 32;

endpackage

// File: rtl/btn_edge.sv
// Button synchronizer (two flops) followed by a registered rising-edge detector.
module btn_edge (
  input  logic Clk100M,
  input  logic rst,
  input  logic btn,
  output logic btnRise
);

  logic sync0;
  logic sync1;
  logic sync_prev;

  always_ff @(posedge Clk100M or posedge rst) begin
    if (rst) begin
      sync0     <= 1'b0;
      sync1     <= 1'b0;
      sync_prev <= 1'b0;
      btnRise   <= 1'b0;
    end else begin
      sync0     <= btn;
      sync1     <= sync0;
      sync_prev <= sync1;
      btnRise   <= sync1 & ~sync_prev;
    end
  end

endmodule

// File: rtl/sym_score_tracker.sv
// Reaction game scorer: counts hits, misses and false presses against target-symbol windows.
// Optional macro FALSE_PRESS_PENALTY_EN: each false press also takes one point off the score.
module sym_score_tracker
  import sym_pkg::*;
#(
  parameter int unsigned RESP_WINDOW = DEF_RESP_WINDOW,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic             Clk100M,
  input  logic             rst,
  input  logic             genSym,
  input  logic             generated,
  input  logic             special,
  input  logic [7:0]       generatedSym,
  input  logic             btn,
  output logic [7:0]       displaySym,
  output logic [CNT_W-1:0] score,
  output logic [CNT_W-1:0] misses,
  output logic [CNT_W-1:0] falsePresses,
  output logic             hitPulse,
  output logic             missPulse,
  output logic             windowOpen
);

  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(RESP_WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] score_d, misses_d, fp_d;
  logic [7:0]       disp_d;
  logic             hit_d, miss_d;
  logic             btn_rise;
  logic             target;

  assign target = generated & special;

  btn_edge u_btn_edge (
    .Clk100M (Clk100M),
    .rst     (rst),
    .btn     (btn),
    .btnRise (btn_rise)
  );

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

`ifdef FALSE_PRESS_PENALTY_EN
  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
    return (v == '0) ? v : v - CNT_W'(1);
  endfunction
`endif

  // Next-state and counter updates; a press always wins over expiry or a new target.
  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    score_d  = score;
    misses_d = misses;
    fp_d     = falsePresses;
    disp_d   = displaySym;
    hit_d    = 1'b0;
    miss_d   = 1'b0;

    if (state_q != IDLE && generated) disp_d = generatedSym;

    if (!genSym) begin
      state_d = IDLE;
      win_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d  = ARMED;
          score_d  = '0;
          misses_d = '0;
          fp_d     = '0;
        end
        ARMED: begin
          if (btn_rise) begin
            fp_d = sat_inc(falsePresses);
`ifdef FALSE_PRESS_PENALTY_EN
            score_d = sat_dec(score);
`endif
          end
          if (target) begin
            state_d = WINDOW;
            win_d   = '0;
          end
        end
        WINDOW: begin
          if (btn_rise) begin
            score_d = sat_inc(score);
            hit_d   = 1'b1;
            if (target) win_d = '0;
            else        state_d = ARMED;
          end else if (target) begin
            misses_d = sat_inc(misses);
            miss_d   = 1'b1;
            win_d    = '0;
          end else if (win_q == WIN_LAST) begin
            misses_d = sat_inc(misses);
            miss_d   = 1'b1;
            state_d  = ARMED;
          end else begin
            win_d = win_q + WIN_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk100M or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      win_q        <= '0;
      score        <= '0;
      misses       <= '0;
      falsePresses <= '0;
      displaySym   <= SYM_RESET;
      hitPulse     <= 1'b0;
      missPulse    <= 1'b0;
      windowOpen   <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_q        <= win_d;
      score        <= score_d;
      misses       <= misses_d;
      falsePresses <= fp_d;
      displaySym   <= disp_d;
      hitPulse     <= hit_d;
      missPulse    <= miss_d;
      windowOpen   <= (state_d == WINDOW);
    end
  end

endmodule

// File: tb/tb_sym_score_tracker.sv
// Scoreboard bench for sym_score_tracker against an edge-indexed reference model.
module tb_sym_score_tracker;

  localparam int unsigned RW  = 8;
  localparam int unsigned CW  = 4;
  localparam int          MAXC = (1 << CW) - 1;
`ifdef FALSE_PRESS_PENALTY_EN
  localparam int PEN = 1;
`else
  localparam int PEN = 0;
`endif

  logic          Clk100M = 1'b0;
  logic          rst = 1'b1;
  logic          genSym = 1'b0, generated = 1'b0, special = 1'b0, btn = 1'b0;
  logic [7:0]    generatedSym = 8'h00;
  logic [7:0]    displaySym;
  logic [CW-1:0] score, misses, falsePresses;
  logic          hitPulse, missPulse, windowOpen;

  sym_score_tracker #(.RESP_WINDOW(RW), .CNT_W(CW)) dut (
    .Clk100M      (Clk100M),
    .rst          (rst),
    .genSym       (genSym),
    .generated    (generated),
    .special      (special),
    .generatedSym (generatedSym),
    .btn          (btn),
    .displaySym   (displaySym),
    .score        (score),
    .misses       (misses),
    .falsePresses (falsePresses),
    .hitPulse     (hitPulse),
    .missPulse    (missPulse),
    .windowOpen   (windowOpen)
  );

  initial forever #5 Clk100M = ~Clk100M;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: absolute edge numbers, deadlines and a sampled button history.
  typedef struct {
    bit is_hit;
    int sc;
    int ms;
    int fp;
  } ev_t;
  ev_t evq[$];

  int       n = 0;
  bit       active = 0, win = 0;
  int       deadline = 0;
  int       m_score = 0, m_miss = 0, m_fp = 0;
  int       m_disp = 255;
  bit       m_hit = 0, m_missp = 0;
  bit [3:0] bh = '0;

  function automatic int sat(input int v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  task automatic push_ev(input bit h);
    ev_t e;
    e.is_hit = h; e.sc = m_score; e.ms = m_miss; e.fp = m_fp;
    evq.push_back(e);
  endtask

  task automatic model_step();
    bit rise, tgt;
    n++;
    if (rst) begin
      active = 0; win = 0; m_score = 0; m_miss = 0; m_fp = 0;
      m_disp = 255; m_hit = 0; m_missp = 0; bh = '0;
      return;
    end
    rise = bh[2] & ~bh[3];
    bh   = {bh[2:0], btn};
    tgt  = generated & special;
    m_hit = 0; m_missp = 0;
    if (active && generated) m_disp = int'(generatedSym);
    if (!genSym) begin
      active = 0; win = 0;
    end else if (!active) begin
      active = 1; win = 0; m_score = 0; m_miss = 0; m_fp = 0;
    end else if (win) begin
      if (rise) begin
        m_score = sat(m_score + 1); m_hit = 1; push_ev(1);
        if (tgt) deadline = n + RW; else win = 0;
      end else if (tgt) begin
        m_miss = sat(m_miss + 1); m_missp = 1; push_ev(0);
        deadline = n + RW;
      end else if (n == deadline) begin
        m_miss = sat(m_miss + 1); m_missp = 1; push_ev(0);
        win = 0;
      end
    end else begin
      if (rise) begin
        m_fp = sat(m_fp + 1);
        if (PEN == 1 && m_score > 0) m_score = m_score - 1;
      end
      if (tgt) begin
        win = 1; deadline = n + RW;
      end
    end
  endtask

  initial forever begin
    @(posedge Clk100M);
    model_step();
  end

  // Monitor: per-cycle output compare, plus event pop on every strobe.
  initial forever begin
    @(negedge Clk100M);
    chk("score", int'(score), m_score);
    chk("misses", int'(misses), m_miss);
    chk("falsePresses", int'(falsePresses), m_fp);
    chk("displaySym", int'(displaySym), m_disp);
    chk("windowOpen", int'(windowOpen), int'(win));
    chk("hitPulse", int'(hitPulse), int'(m_hit));
    chk("missPulse", int'(missPulse), int'(m_missp));
    if (hitPulse || missPulse) begin
      if (evq.size() == 0) begin
        chk("event_expected", 0, 1);
      end else begin
        ev_t e;
        e = evq.pop_front();
        chk("ev_kind_hit", int'(hitPulse), int'(e.is_hit));
        chk("ev_score", int'(score), e.sc);
        chk("ev_misses", int'(misses), e.ms);
        chk("ev_false", int'(falsePresses), e.fp);
      end
    end
  end

  task automatic cyc(input bit g, input bit s, input bit b);
    @(negedge Clk100M);
    generated    = g;
    special      = s;
    btn          = b;
    generatedSym = 8'($urandom_range(0, 254));
  endtask

  task automatic idle(input int k);
    repeat (k) cyc(0, 0, 0);
  endtask

  task automatic hit_seq();
    cyc(1, 1, 0);
    repeat (3) cyc(0, 0, 1);
    idle(4);
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_score"}, int'(score), 0);
    chk({tag, "_misses"}, int'(misses), 0);
    chk({tag, "_false"}, int'(falsePresses), 0);
    chk({tag, "_disp"}, int'(displaySym), 255);
    chk({tag, "_win"}, int'(windowOpen), 0);
    chk({tag, "_pulses"}, int'({hitPulse, missPulse}), 0);
  endtask

  initial begin
    repeat (3) @(negedge Clk100M);
    reset_check("reset");
    rst = 1'b0;
    genSym = 1'b1;
    idle(2);

    hit_seq();
    chk("first_hit_score", int'(score), 1);

    cyc(1, 1, 0);
    idle(10);
    chk("expiry_miss", int'(misses), 1);

    repeat (2) begin
      repeat (2) cyc(0, 0, 1);
      idle(2);
    end
    idle(3);
    chk("false_presses", int'(falsePresses), 2);
    chk("false_penalty_score", int'(score), 1 - PEN);

    cyc(1, 1, 0);
    cyc(0, 0, 0); cyc(1, 0, 0); cyc(0, 0, 0);
    cyc(1, 1, 0);
    idle(3); cyc(1, 0, 0); idle(6);
    chk("supersede_misses", int'(misses), 3);

    cyc(1, 1, 0);
    idle(4);
    repeat (3) cyc(0, 0, 1);
    idle(4);
    chk("expiry_cycle_hit", int'(score), 2 - PEN);
    chk("expiry_cycle_misses", int'(misses), 3);

    repeat (17) hit_seq();
    chk("score_saturates", int'(score), MAXC);

    cyc(1, 1, 0);
    repeat (3) cyc(0, 0, 1);
    cyc(1, 1, 1);
    idle(10);
    chk("hit_and_target_misses", int'(misses), 4);

    @(negedge Clk100M); genSym = 1'b0;
    idle(2);
    genSym = 1'b1;
    idle(3);
    chk("restart_clear_score", int'(score), 0);
    chk("restart_clear_misses", int'(misses), 0);

    cyc(1, 1, 0);
    idle(2);
    @(negedge Clk100M);
    #2 rst = 1'b1;
    #1 reset_check("rst_mid_window");
    idle(2);
    rst = 1'b0;
    idle(4);

    repeat (3000) begin
      cyc(($urandom_range(0, 5) == 0), ($urandom_range(0, 1) == 1),
          ($urandom_range(0, 4) == 0) ? ~btn : btn);
      rst = 1'b0;
      if (!genSym) genSym = ($urandom_range(0, 3) == 0);
      else if ($urandom_range(0, 249) == 0) genSym = 1'b0;
      if ($urandom_range(0, 999) == 0) #2 rst = 1'b1;
    end
    rst = 1'b0;
    idle(12);
    chk("events_drained", evq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
